// File: rtl/data_mem_pkg.sv
// Shared encodings for the parametrised data memory: access sizes, default
// LED register address, legacy-store FSM states and the alignment check.
package data_mem_pkg;

  localparam logic [2:0]  SZ_BYTE          = 3'b001;
  localparam logic [2:0]  SZ_HALF          = 3'b011;
  localparam logic [2:0]  SZ_WORD          = 3'b111;
  localparam logic [31:0] LED_ADDR_DEFAULT = 32'h0000_2000;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  // Bytes are always aligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    return ((size == SZ_HALF) && off[0]) || ((size == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_param_lane.sv
// Byte-lane steering: store-side byte enables / replicated data and
// load-side lane extraction with zero or sign extension.
module mem_byte_lane
  import data_mem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = ld_word[{off, 3'b000} +: 8];
    half_sel = ld_word[{off[1], 4'b0000} +: 16];
  end

  always_comb begin
    st_be   = 4'b0001 << off;
    st_data = {4{wdata[7:0]}};
    ld_data = {{24{sign & byte_sel[7]}}, byte_sel};
    case (size)
      SZ_WORD: begin
        st_be   = 4'b1111;
        st_data = wdata;
        ld_data = ld_word;
      end
      SZ_HALF: begin
        st_be   = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata[15:0]}};
        ld_data = {{16{sign & half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_param.sv
// RV32I data memory with a one-entry store buffer (or legacy stalling
// read-modify-write), load forwarding, misalignment pulse and LED MMIO.
module data_mem_param
  import data_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          STORE_BUF   = 1,
  parameter logic [31:0] LED_ADDR    = LED_ADDR_DEFAULT,
  parameter int          LED_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e                 state_q, state_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [AW-1:0]          pend_idx_q, pend_idx_d;
  logic [3:0]             pend_be_q, pend_be_d;
  logic [31:0]            pend_data_q, pend_data_d;
  logic [31:0]            read_data_q, read_data_d;
  logic [LED_WIDTH-1:0]   led_q, led_d;
  logic                   clk_stall_q, clk_stall_d;
  logic                   misaligned_q, misaligned_d;

  logic [AW-1:0] idx;
  logic [2:0]    size;
  logic          bad, is_led, accept, commit;
  logic [3:0]    st_be;
  logic [31:0]   st_data, ld_word, ld_data, led_ext;

  always_comb begin
    idx    = addr[AW+1:2];
    size   = sign_mask[2:0];
    bad    = is_misaligned(size, addr[1:0]);
    is_led = (addr == LED_ADDR);
    accept = (STORE_BUF != 0) || (state_q == IDLE);
    commit = pend_vld_q && rst_n;
  end

  always_comb begin
    led_ext                = '0;
    led_ext[LED_WIDTH-1:0] = led_q;
  end

  // Array word overlaid with the pending store bytes when the index matches.
  always_comb begin
    ld_word = mem_q[idx];
    for (int b = 0; b < 4; b++) begin
      if (pend_vld_q && (pend_idx_q == idx) && pend_be_q[b]) begin
        ld_word[8*b +: 8] = pend_data_q[8*b +: 8];
      end
    end
  end

  mem_byte_lane u_lane (
    .off     (addr[1:0]),
    .size    (size),
    .sign    (sign_mask[3]),
    .wdata   (write_data),
    .st_be   (st_be),
    .st_data (st_data),
    .ld_word (ld_word),
    .ld_data (ld_data)
  );

  always_comb begin
    state_d      = state_q;
    pend_vld_d   = 1'b0;
    pend_idx_d   = pend_idx_q;
    pend_be_d    = pend_be_q;
    pend_data_d  = pend_data_q;
    read_data_d  = read_data_q;
    led_d        = led_q;
    clk_stall_d  = 1'b0;
    misaligned_d = 1'b0;

    if (state_q == COMMIT) begin
      state_d = IDLE;
    end

    if (accept) begin
      if (memwrite) begin
        if (bad) begin
          misaligned_d = 1'b1;
        end else if (is_led) begin
          led_d = write_data[LED_WIDTH-1:0];
        end else begin
          pend_vld_d  = 1'b1;
          pend_idx_d  = idx;
          pend_be_d   = st_be;
          pend_data_d = st_data;
          if (STORE_BUF == 0) begin
            state_d     = COMMIT;
            clk_stall_d = 1'b1;
          end
        end
      end else if (memread) begin
        if (bad) begin
          misaligned_d = 1'b1;
        end else if (is_led) begin
          read_data_d = led_ext;
        end else begin
          read_data_d = ld_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_vld_q   <= 1'b0;
      read_data_q  <= '0;
      led_q        <= '0;
      clk_stall_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_vld_q   <= pend_vld_d;
      read_data_q  <= read_data_d;
      led_q        <= led_d;
      clk_stall_q  <= clk_stall_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_idx_q  <= pend_idx_d;
    pend_be_q   <= pend_be_d;
    pend_data_q <= pend_data_d;
  end

  // Commit is gated by reset so a store still pending at reset is dropped.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int b = 0; b < 4; b++) begin
        if (pend_be_q[b]) begin
          mem_q[pend_idx_q][8*b +: 8] <= pend_data_q[8*b +: 8];
        end
      end
    end
  end

  assign read_data  = read_data_q;
  assign led        = led_q;
  assign clk_stall  = clk_stall_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_data_mem_param.sv
// Directed bench: one buffered-store instance and one legacy-stall instance,
// each with its own input set, checked with immediate assertions.
module tb_data_mem_param;

  localparam logic [3:0] LW = 4'b0111, LH = 4'b1011, LHU = 4'b0011;
  localparam logic [3:0] LB = 4'b1001, LBU = 4'b0001;
  localparam logic [3:0] SW = 4'b0111, SH = 4'b0011, SB = 4'b0001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic        we   [2];
  logic        re   [2];
  logic [3:0]  sm   [2];
  logic [31:0] rd   [2];
  logic [7:0]  led  [2];
  logic        stall[2];
  logic        mis  [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_mem_param #(.STORE_BUF(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .addr(addr[0]), .write_data(wd[0]),
    .memwrite(we[0]), .memread(re[0]), .sign_mask(sm[0]),
    .read_data(rd[0]), .led(led[0]), .clk_stall(stall[0]), .misaligned(mis[0])
  );

  data_mem_param #(.STORE_BUF(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .addr(addr[1]), .write_data(wd[1]),
    .memwrite(we[1]), .memread(re[1]), .sign_mask(sm[1]),
    .read_data(rd[1]), .led(led[1]), .clk_stall(stall[1]), .misaligned(mis[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input int u, input logic w, input logic r, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] m);
    we[u] = w; re[u] = r; addr[u] = a; wd[u] = d; sm[u] = m;
  endtask

  task automatic idle_all();
    op(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    op(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    step();
    step();
    for (int u = 0; u < 2; u++) begin
      chk("rst_rd",    rd[u], 32'h0);
      chk("rst_led",   32'(led[u]), 32'h0);
      chk("rst_stall", 32'(stall[u]), 32'h0);
      chk("rst_mis",   32'(mis[u]), 32'h0);
    end
    rst_n = 1'b1;

    // Buffered mode: store then forwarded load, then array load.
    op(0, 1, 0, 32'h10, 32'hDEADBEEF, SW); step();
    chk("sw_stall", 32'(stall[0]), 32'h0);
    op(0, 0, 1, 32'h10, 32'h0, LW); step();
    chk("lw_fwd", rd[0], 32'hDEADBEEF);
    chk("lw_fwd_stall", 32'(stall[0]), 32'h0);
    op(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
    op(0, 0, 1, 32'h10, 32'h0, LW); step();
    chk("lw_array", rd[0], 32'hDEADBEEF);
    op(0, 0, 1, 32'h1010, 32'h0, LW); step();
    chk("lw_alias", rd[0], 32'hDEADBEEF);

    // Sub-word extension.
    op(0, 1, 0, 32'h20, 32'h80FF7F01, SW); step();
    op(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
    op(0, 0, 1, 32'h23, 32'h0, LB);  step(); chk("lb",  rd[0], 32'hFFFFFF80);
    op(0, 0, 1, 32'h23, 32'h0, LBU); step(); chk("lbu", rd[0], 32'h00000080);
    op(0, 0, 1, 32'h22, 32'h0, LH);  step(); chk("lh",  rd[0], 32'hFFFF80FF);
    op(0, 0, 1, 32'h20, 32'h0, LHU); step(); chk("lhu", rd[0], 32'h00007F01);
    op(0, 0, 1, 32'h21, 32'h0, LB);  step(); chk("lb_pos", rd[0], 32'h0000007F);

    // Partial forwarding.
    op(0, 1, 0, 32'h30, 32'h11223344, SW); step();
    op(0, 1, 0, 32'h31, 32'h000000AA, SB); step();
    op(0, 0, 1, 32'h30, 32'h0, LW); step();
    chk("fwd_sb", rd[0], 32'h1122AA44);
    op(0, 1, 0, 32'h32, 32'h00000055, SB); step();
    op(0, 0, 1, 32'h30, 32'h0, LW); step();
    chk("fwd_sb2", rd[0], 32'h1155AA44);

    // Back-to-back stores: commit and capture on the same edge.
    op(0, 1, 0, 32'h34, 32'h00000000, SW); step();
    op(0, 1, 0, 32'h34, 32'h00000011, SB); step();
    op(0, 1, 0, 32'h35, 32'h00000022, SB); step();
    op(0, 0, 1, 32'h34, 32'h0, LW); step();
    chk("b2b_sb", rd[0], 32'h00002211);
    op(0, 1, 0, 32'h36, 32'hFFFF8899, SH); step();
    op(0, 0, 1, 32'h36, 32'h0, LH); step();
    chk("fwd_sh", rd[0], 32'hFFFF8899);

    // Misalignment: pulse for one cycle, read_data held, no array change.
    op(0, 0, 1, 32'h41, 32'h0, LW); step();
    chk("mis_lw", 32'(mis[0]), 32'h1);
    chk("mis_rd_hold", rd[0], 32'hFFFF8899);
    op(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
    chk("mis_pulse_end", 32'(mis[0]), 32'h0);
    op(0, 1, 0, 32'h11, 32'hFFFFFFFF, SW); step();
    chk("mis_sw", 32'(mis[0]), 32'h1);
    op(0, 0, 1, 32'h33, 32'h0, LH); step();
    chk("mis_lh", 32'(mis[0]), 32'h1);
    op(0, 0, 1, 32'h10, 32'h0, LW); step();
    chk("mis_sw_nowrite", rd[0], 32'hDEADBEEF);
    chk("mis_clear", 32'(mis[0]), 32'h0);

    // Store beats load; read_data held.
    op(0, 1, 1, 32'h60, 32'h00000077, SW); step();
    chk("prio_hold", rd[0], 32'hDEADBEEF);
    op(0, 0, 1, 32'h60, 32'h0, LW); step();
    chk("prio_store", rd[0], 32'h00000077);

    // LED MMIO.
    op(0, 1, 0, 32'h0, 32'h0BADF00D, SW); step();
    op(0, 1, 0, 32'h2000, 32'h000000A5, SW); step();
    chk("led_sw", 32'(led[0]), 32'hA5);
    op(0, 0, 1, 32'h2000, 32'h0, LW); step();
    chk("led_lw", rd[0], 32'h000000A5);
    op(0, 0, 1, 32'h0, 32'h0, LW); step();
    chk("led_alias", rd[0], 32'h0BADF00D);
    op(0, 1, 0, 32'h2000, 32'h00001234, SH); step();
    chk("led_sh", 32'(led[0]), 32'h34);

    // Reset drops the pending store.
    op(0, 1, 0, 32'h50, 32'hCAFEF00D, SW); step();
    op(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
    op(0, 1, 0, 32'h50, 32'h12345678, SW); step();
    rst_n = 1'b0;
    op(0, 0, 0, 32'h0, 32'h0, 4'h0); step();
    chk("rst2_rd",    rd[0], 32'h0);
    chk("rst2_led",   32'(led[0]), 32'h0);
    chk("rst2_stall", 32'(stall[0]), 32'h0);
    chk("rst2_mis",   32'(mis[0]), 32'h0);
    rst_n = 1'b1;
    op(0, 0, 1, 32'h50, 32'h0, LW); step();
    chk("rst_drop", rd[0], 32'hCAFEF00D);
    op(0, 0, 0, 32'h0, 32'h0, 4'h0);

    // Legacy mode: one-cycle stall, inputs ignored while committing.
    op(1, 1, 0, 32'h40, 32'h1234ABCD, SW); step();
    chk("leg_sw_stall", 32'(stall[1]), 32'h1);
    op(1, 0, 0, 32'h0, 32'h0, 4'h0); step();
    chk("leg_sw_unstall", 32'(stall[1]), 32'h0);
    op(1, 1, 0, 32'h42, 32'h0000BEEF, SH); step();
    chk("leg_sh_stall", 32'(stall[1]), 32'h1);
    op(1, 1, 0, 32'h40, 32'hFFFFFFFF, SW); step();
    chk("leg_sh_unstall", 32'(stall[1]), 32'h0);
    op(1, 0, 1, 32'h40, 32'h0, LW); step();
    chk("leg_lw", rd[1], 32'hBEEFABCD);
    chk("leg_lw_nostall", 32'(stall[1]), 32'h0);
    op(1, 0, 1, 32'h43, 32'h0, LW); step();
    chk("leg_mis", 32'(mis[1]), 32'h1);
    chk("leg_mis_hold", rd[1], 32'hBEEFABCD);
    op(1, 0, 0, 32'h0, 32'h0, 4'h0); step();
    chk("leg_mis_end", 32'(mis[1]), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_param.md
Name: data_mem_param

Overview:
- Parametrised successor to the single-port data memory with byte/half/word access on the RV32I data path.
- Adds a one-entry store buffer with load forwarding so stores no longer stall.
- Adds a legacy stall mode, misalignment detection, synchronous active-low reset, and a width-configurable LED MMIO register.
- Sits between the EX/MEM pipeline register and the writeback mux.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; power of 2.
- STORE_BUF, 1: 1 = buffered stores, no stall; 0 = legacy read-modify-write with a one-cycle clk_stall.
- LED_ADDR, 32'h2000: byte address of the LED register.
- LED_WIDTH, 8: width of the led output; 1..32.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- addr  in  32  byte address.
- write_data  in  32  store data, right-aligned.
- memwrite  in  1  store request this cycle.
- memread  in  1  load request this cycle.
- sign_mask  in  4  bit 3 = sign-extend; [2:0] = 001 byte, 011 half, 111 word.
- read_data  out  32  registered load result.
- led  out  LED_WIDTH  LED register.
- clk_stall  out  1  pipeline hold; used only when STORE_BUF = 0.
- misaligned  out  1  one-cycle error pulse.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - read_data = 0, led = 0, clk_stall = 0, misaligned = 0.
  - Pending-store valid flag cleared; an uncommitted store is discarded.
  - FSM returns to IDLE, aborting any legacy write.
  - Array contents are not reset.
- Indexing: word index = addr[log2(DEPTH_WORDS)+1:2]; higher address bits alias (wrap).
- Misaligned access: half at addr[0] = 1, or word at addr[1:0] != 0.
  - No array or LED change; read_data held.
  - misaligned = 1 for exactly the following cycle.
- Priority: memwrite beats memread when both are high; the read is ignored and read_data is held.
- Load latency = 1:
  - Request sampled at edge N; read_data valid after edge N and held until the next accepted load.
  - Byte/half lane chosen by addr[1:0], then zero- or sign-extended per sign_mask[3].
- LED MMIO:
  - Store to LED_ADDR: led <= write_data[LED_WIDTH-1:0], regardless of size; the array is not written.
  - Load from LED_ADDR returns the zero-extended LED value.
- STORE_BUF = 1:
  - Store at edge N is captured into the pending entry: word index, 4-bit byte-enable, lane-aligned data.
  - Pending entry commits (byte-enabled write) at edge N+1.
  - Back-to-back stores: commit and capture happen on the same edge; the buffer never fills; clk_stall is tied 0.
  - Load at N+1 hitting the pending word index: result = array word with enabled bytes replaced by pending bytes (forwarding).
  - Load at N+1 to a different index reads the array normally.
- STORE_BUF = 0, FSM states IDLE and COMMIT:
  - IDLE + valid store: latch addr/data/mask, clk_stall <= 1, go to COMMIT.
  - COMMIT: write merged word, clk_stall <= 0, return to IDLE.
  - Inputs arriving during COMMIT are ignored; the pipeline is held by clk_stall.
  - Loads in IDLE behave as above with latency 1.
- Loads never stall in either mode.
- All outputs driven from registers; no combinational input-to-output path.

Decomposition:
- Package data_mem_pkg:
  - Size encodings SZ_BYTE = 3'b001, SZ_HALF = 3'b011, SZ_WORD = 3'b111.
  - Default LED_ADDR.
  - FSM state constants IDLE and COMMIT.
- Sub-module mem_byte_lane (combinational):
  - Store side: from addr[1:0], size and write_data, produces the 4-bit byte-enable and lane-aligned data.
  - Load side: from a 32-bit word, addr[1:0], size and sign, produces the extracted, extended result.
  - Instantiated once; top holds the array, pending entry, FSM and LED register.

Test Plan:
- Word store then load, STORE_BUF = 1:
  - SW 0xDEADBEEF at 0x10; next cycle LW 0x10 -> read_data = 0xDEADBEEF (forwarded); clk_stall stays 0.
  - LW 0x10 two cycles later -> 0xDEADBEEF from the array.
- Byte/half extension: word 0x80FF7F01 at 0x20:
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080.
  - LH 0x22 -> 0xFFFF80FF; LHU 0x20 -> 0x00007F01.
- Partial forwarding:
  - Word 0x11223344 at 0x30; SB 0xAA at 0x31; next-cycle LW 0x30 -> 0x1122AA44.
  - Back-to-back SB 0x55 at 0x32 then LW -> 0x1155AA44.
- Legacy mode, STORE_BUF = 0:
  - SH 0xBEEF at 0x42 -> clk_stall high exactly one cycle.
  - Input change during the stall ignored; LW 0x40 afterwards -> 0xBEEFxxxx with the low half preserved.
- Misaligned/MMIO:
  - LW 0x41 -> misaligned pulses one cycle, read_data unchanged.
  - SW 0x000000A5 to 0x2000 -> led = 0xA5; array word at alias 0x000 unchanged.
- Reset:
  - SW 0x12345678 at 0x50, then rst_n = 0 on the next edge -> pending store dropped, LW 0x50 returns the old value.
  - Outputs all zero during reset.
